dsp_op_sched: RTL and testbench

DSP_OP_SCHED -- requirements
Module: dsp_op_sched

---
 rtl/dsp_op_sched.sv | 157 +++++++++++++++
 tb/tb_dsp_op_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_op_sched.sv
// Two-requester scheduler for one DSP multiplier/accumulator with credit flow control and a result FIFO.
// Define DSP_SCHED_RR_EN for round-robin arbitration in OPEN; otherwise requester 0 has fixed priority.
module dsp_op_sched #(
  parameter int unsigned LAT        = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][1:0]  req_op,
  input  logic [1:0][24:0] req_a,
  input  logic [1:0][17:0] req_b,
  output logic [29:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [4:0]       dsp_inmode,
  output logic [3:0]       dsp_alumode,
  output logic [6:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_p,
  output logic             res_id
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(FIFO_DEPTH - 1);

  localparam logic [1:0] OpMul     = 2'd0;
  localparam logic [1:0] OpMacInit = 2'd1;
  localparam logic [1:0] OpMac     = 2'd2;
  localparam logic [1:0] OpMacLast = 2'd3;

  localparam logic [6:0] OpmodeMul  = 7'h05;
  localparam logic [6:0] OpmodeMac  = 7'h25;
  localparam logic [6:0] OpmodeHold = 7'h20;

  typedef enum logic [1:0] {StOpen, StLock0, StLock1} state_e;

  state_e          state_q, state_d;
  logic            init_q;
  logic [CW-1:0]   credit_q, credit_d;
  logic [LAT-1:0]  tag_v_q, tag_id_q;
  logic [29:0]     dsp_a_q;
  logic [17:0]     dsp_b_q;
  logic [6:0]      dsp_opmode_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [48:0]     mem_q [FIFO_DEPTH];
`ifdef DSP_SCHED_RR_EN
  logic            prio_q;
`endif

  logic       v0, v1, sel, accept, wr, pop;
  logic [1:0] sel_op;

  always_comb begin
    v0 = req_valid[0] & (state_q != StLock1);
    v1 = req_valid[1] & (state_q != StLock0);
`ifdef DSP_SCHED_RR_EN
    sel = (v0 & v1) ? prio_q : ~v0;
`else
    sel = ~v0;
`endif
    // init_q keeps the first cycle after reset release closed to new ops
    accept    = init_q & (credit_q < CW'(FIFO_DEPTH)) & (v0 | v1);
    req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
    sel_op    = req_op[sel];
    wr        = tag_v_q[LAT-1];
    pop       = res_valid & res_ready;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        StOpen: begin
          if (sel_op == OpMacInit || sel_op == OpMac) state_d = sel ? StLock1 : StLock0;
        end
        StLock0, StLock1: begin
          if (sel_op == OpMacLast) state_d = StOpen;
        end
        default: state_d = StOpen;
      endcase
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + 1'b1;
    else if (!accept && pop) credit_d = credit_q - 1'b1;
    fifo_cnt_d = fifo_cnt_q;
    if (wr && !pop)          fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!wr && pop)     fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StOpen;
      init_q       <= 1'b0;
      credit_q     <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      dsp_opmode_q <= OpmodeHold;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
`ifdef DSP_SCHED_RR_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      credit_q   <= credit_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int k = LAT - 1; k > 0; k--) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      tag_v_q[0]  <= accept;
      tag_id_q[0] <= sel;
      if (accept) begin
        dsp_a_q      <= {{5{req_a[sel][24]}}, req_a[sel]};
        dsp_b_q      <= req_b[sel];
        dsp_opmode_q <= (sel_op == OpMul || sel_op == OpMacInit) ? OpmodeMul : OpmodeMac;
`ifdef DSP_SCHED_RR_EN
        prio_q       <= ~sel;
`endif
      end else begin
        dsp_a_q      <= '0;
        dsp_b_q      <= '0;
        dsp_opmode_q <= OpmodeHold;
      end
      if (wr)  wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], dsp_p};
  end

  always_comb begin
    dsp_a       = dsp_a_q;
    dsp_b       = dsp_b_q;
    dsp_opmode  = dsp_opmode_q;
    dsp_inmode  = 5'b00000;
    dsp_alumode = 4'b0000;
    res_valid   = (fifo_cnt_q != '0);
    {res_id, res_p} = res_valid ? mem_q[rd_ptr_q] : 49'd0;
  end

endmodule

// File: tb/tb_dsp_op_sched.sv
// Directed bench for dsp_op_sched with a behavioural DSP and a result scoreboard.
// Assumes LAT = 3: the DSP model registers the ports once, then updates P.
module tb_dsp_op_sched;

  localparam int unsigned LAT        = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [1:0] OpMul     = 2'd0;
  localparam logic [1:0] OpMacInit = 2'd1;
  localparam logic [1:0] OpMac     = 2'd2;
  localparam logic [1:0] OpMacLast = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_op = '0;
  logic [1:0][24:0] req_a = '0;
  logic [1:0][17:0] req_b = '0;
  logic [29:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [4:0]       dsp_inmode;
  logic [3:0]       dsp_alumode;
  logic [6:0]       dsp_opmode;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [47:0]      res_p;
  logic             res_id;

  always #5 clk = ~clk;

  dsp_op_sched #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_inmode(dsp_inmode),
    .dsp_alumode(dsp_alumode), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_pop    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] sext_mul(input logic [47:0] a, input logic [47:0] b);
    return a * b;
  endfunction

  // Behavioural DSP: ports registered once, then P updated per opmode
  logic [54:0] dsp_s0  = {7'h20, 48'd0};
  logic [47:0] p_model = '0;
  always @(posedge clk) begin
    dsp_s0 <= {dsp_opmode, dsp_a, dsp_b};
    case (dsp_s0[54:48])
      7'h05: p_model <= sext_mul({{18{dsp_s0[47]}}, dsp_s0[47:18]}, {{30{dsp_s0[17]}}, dsp_s0[17:0]});
      7'h25: p_model <= p_model +
                        sext_mul({{18{dsp_s0[47]}}, dsp_s0[47:18]}, {{30{dsp_s0[17]}}, dsp_s0[17:0]});
      default: ;
    endcase
  end
  assign dsp_p = p_model;

  // Scoreboard: expected {id, P} pushed at accept, compared at pop
  logic [48:0] sb_q[$];
  logic        grant_log[$];
  logic [47:0] acc_model = '0;
  logic [47:0] prod;
  logic [47:0] last_res = '0;
  logic [48:0] exp_e;
  logic        gi;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if ((req_valid & req_ready) != 2'b00) begin
        gi   = req_ready[1];
        prod = sext_mul({{23{req_a[gi][24]}}, req_a[gi]}, {{30{req_b[gi][17]}}, req_b[gi]});
        if (req_op[gi] == OpMul || req_op[gi] == OpMacInit) acc_model = prod;
        else acc_model = acc_model + prod;
        sb_q.push_back({gi, acc_model});
        grant_log.push_back(gi);
        n_accept++;
      end
      if (res_valid && res_ready) begin
        chk("result_without_op", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          exp_e = sb_q.pop_front();
          chk("res_p", 64'(res_p), 64'(exp_e[47:0]));
          chk("res_id", 64'(res_id), 64'(exp_e[48]));
        end
        last_res = res_p;
        n_pop++;
      end
    end
  end

  task automatic drive(input int r, input logic v, input logic [1:0] op, input int a, input int b);
    req_valid[r] = v;
    req_op[r]    = op;
    req_a[r]     = 25'(a);
    req_b[r]     = 18'(b);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n = 0;
    while (n_accept < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 64'(n_accept >= target), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(sb_q.size() == 0), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    int p0;
    int mark;

    // Reset values, with a request already pending
    drive(0, 1'b1, OpMul, 3, -4);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_p", 64'(res_p), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_dsp_b", 64'(dsp_b), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'h20);
    chk("inmode", 64'(dsp_inmode), 64'd0);
    chk("alumode", 64'(dsp_alumode), 64'd0);

    // Single MUL 3 * -4
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mul_ready", 64'(req_ready), 64'b01);
    @(posedge clk); #1 drive(0, 1'b0, OpMul, 0, 0);
    @(negedge clk);
    chk("mul_opmode", 64'(dsp_opmode), 64'h05);
    chk("mul_dsp_a", 64'(dsp_a), 64'd3);
    chk("mul_dsp_b", 64'(dsp_b), 64'h3FFFC);
    @(negedge clk);
    chk("mul_opmode_idle", 64'(dsp_opmode), 64'h20);
    chk("mul_dsp_a_idle", 64'(dsp_a), 64'd0);
    chk("mul_lat_e1", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("mul_lat_e2", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("mul_lat_e3", 64'(res_valid), 64'd1);
    chk("mul_res_p", 64'(res_p), 64'hFFFF_FFFF_FFF4);
    chk("mul_res_id", 64'(res_id), 64'd0);
    drain(20);

    // Lock: req1 MAC chain blocks a waiting req0
    drive(1, 1'b1, OpMacInit, 2, 5);
    @(negedge clk);
    chk("lock_ready0", 64'(req_ready), 64'b10);
    @(posedge clk); #1;
    drive(1, 1'b1, OpMac, 3, 3);
    drive(0, 1'b1, OpMul, 1, 1);
    @(negedge clk);
    chk("lock_ready1", 64'(req_ready), 64'b10);
    @(posedge clk); #1 drive(1, 1'b1, OpMacLast, 1, 1);
    @(negedge clk);
    chk("lock_ready2", 64'(req_ready), 64'b10);
    @(posedge clk); #1 drive(1, 1'b0, OpMul, 0, 0);
    @(negedge clk);
    chk("unlock_ready", 64'(req_ready), 64'b01);
    @(posedge clk); #1 drive(0, 1'b0, OpMul, 0, 0);
    drain(30);
    chk("lock_last_res", 64'(last_res), 64'd1);

    // Backpressure: credits run out after FIFO_DEPTH accepts
    res_ready = 1'b0;
    c0 = n_accept;
    p0 = n_pop;
    drive(0, 1'b1, OpMul, 5, -3);
    repeat (10) begin
      @(posedge clk); #1;
      req_a[0] = 25'(5 + n_accept - c0);
    end
    @(negedge clk);
    chk("bp_accepts", 64'(n_accept - c0), 64'd4);
    chk("bp_ready", 64'(req_ready), 64'd0);
    chk("bp_res_valid", 64'(res_valid), 64'd1);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_accepts(c0 + 5, 20);
    drive(0, 1'b0, OpMul, 0, 0);
    drain(30);
    chk("bp_pops", 64'(n_pop - p0), 64'd5);

    // Reset with two ops in flight and one in the FIFO
    res_ready = 1'b0;
    c0 = n_accept;
    drive(0, 1'b1, OpMul, 9, 9);
    wait_accepts(c0 + 3, 20);
    drive(0, 1'b0, OpMul, 0, 0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_p", 64'(res_p), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_opmode", 64'(dsp_opmode), 64'h20);
    chk("mid_rst_dsp_a", 64'(dsp_a), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, OpMul, 2, 3);
    drive(1, 1'b1, OpMul, -5, 7);
    res_ready = 1'b1;
    p0 = n_pop;
    mark = grant_log.size();
    c0 = n_accept;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_res_valid", 64'(res_valid), 64'd0);
    chk("rel_req_ready", 64'(req_ready), 64'd0);

    // Arbitration with both requesters continuously valid
    wait_accepts(c0 + 6, 40);
    req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin
`ifdef DSP_SCHED_RR_EN
      chk($sformatf("grant%0d", k), 64'(grant_log[mark + k]), 64'(k % 2));
`else
      chk($sformatf("grant%0d", k), 64'(grant_log[mark + k]), 64'd0);
`endif
    end
    drain(30);
    chk("post_rst_pops", 64'(n_pop - p0), 64'd6);

    // MAC chain with an idle gap
    drive(1, 1'b1, OpMacInit, 1, 1);
    @(negedge clk);
    chk("gap_ready", 64'(req_ready), 64'b10);
    @(posedge clk); #1 drive(1, 1'b0, OpMul, 0, 0);
    @(negedge clk);
    chk("gap_opmode_init", 64'(dsp_opmode), 64'h05);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) drive(1, 1'b1, OpMacLast, 1, 1);
      @(negedge clk);
      chk($sformatf("gap_opmode%0d", k), 64'(dsp_opmode), 64'h20);
    end
    chk("gap_last_ready", 64'(req_ready), 64'b10);
    @(posedge clk); #1 drive(1, 1'b0, OpMul, 0, 0);
    @(negedge clk);
    chk("gap_opmode_last", 64'(dsp_opmode), 64'h25);
    drain(30);
    chk("gap_final", 64'(last_res), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
